fetch_buffer: RTL and testbench

// - Decoupling buffer between fetch stage and decode stage.
// - Accepts 32-bit fetch words and stores them as 16-bit halfwords in a circular FIFO.
// - Reassembles 16-bit and 32-bit instructions with their PCs and presents one instruction per cycle to decode.
// - Flow control back to fetch: buf_stall. From decode/execute: pipe_stall.

---
 rtl/fetch_buffer.sv | 128 ++++++++++++
 tb/tb_fetch_buffer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - halfword FIFO between fetch and decode that reassembles 16/32-bit instructions
// Optional RVC support under `define COMPRESSED_EN; default build treats every instruction as 32-bit.
module fetch_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_rdata,
  input  logic        fetch_ready,
  input  logic        fetch_align,
  input  logic        fetch_clear,
  input  logic        pipe_stall,
  output logic [31:0] buf_pc,
  output logic [31:0] buf_instr,
  output logic        buf_done,
  output logic        buf_stall
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ZERO = '0;
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_TWO  = (PW+1)'(2);
  localparam logic [PW:0]   CNT_HI   = (PW+1)'(DEPTH-2);

  logic [15:0]   hw_mem [DEPTH];
  logic [30:0]   pc_mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr_p1;
  logic [PW-1:0] wr_ptr_p1;
  logic [PW:0]   count;
  logic [PW:0]   push_n;
  logic [PW:0]   pop_n;

  logic          align_eff;
  logic          is_16;
  logic          avail;
  logic          push;
  logic          pop;
  logic [15:0]   h0_hw;
  logic [15:0]   h1_hw;
  logic [30:0]   h0_pc;
  logic [29:0]   word_pc;

`ifdef COMPRESSED_EN
  logic          unused_pc_bits;
  assign unused_pc_bits = ^fetch_pc[1:0];
  assign align_eff      = fetch_align;
  assign is_16          = (h0_hw[1:0] != 2'b11);
`else
  // Without RVC every entry pair is one instruction, so rd_ptr stays even.
  logic          unused_inputs;
  assign unused_inputs  = ^{fetch_pc[1:0], fetch_align};
  assign align_eff      = 1'b0;
  assign is_16          = 1'b0;
`endif

  assign word_pc   = fetch_pc[31:2];
  assign rd_ptr_p1 = rd_ptr + PTR_ONE;
  assign wr_ptr_p1 = wr_ptr + PTR_ONE;

  assign h0_hw = hw_mem[rd_ptr];
  assign h0_pc = pc_mem[rd_ptr];
  assign h1_hw = hw_mem[rd_ptr_p1];

  // Only registered count feeds buf_stall, keeping fetch free of input-to-output paths.
  assign buf_stall = (count > CNT_HI);
  assign avail     = is_16 ? (count >= CNT_ONE) : (count >= CNT_TWO);

  always_comb begin
    buf_done  = avail & ~fetch_clear;
    buf_pc    = '0;
    buf_instr = '0;
    if (buf_done) begin
      buf_pc    = {h0_pc, 1'b0};
      buf_instr = is_16 ? {16'h0000, h0_hw} : {h1_hw, h0_hw};
    end
  end

  assign push = fetch_ready & ~buf_stall & ~fetch_clear;
  assign pop  = buf_done & ~pipe_stall;

  always_comb begin
    push_n = CNT_ZERO;
    pop_n  = CNT_ZERO;
    if (push) begin
      push_n = align_eff ? CNT_ONE : CNT_TWO;
    end
    if (pop) begin
      pop_n = is_16 ? CNT_ONE : CNT_TWO;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (fetch_clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + pop_n[PW-1:0];
      wr_ptr <= wr_ptr + push_n[PW-1:0];
      count  <= count + push_n - pop_n;
    end
  end

  // Storage needs no reset: nothing is presented until count covers the entries read.
  always_ff @(posedge clock) begin
    if (push) begin
      if (align_eff) begin
        hw_mem[wr_ptr] <= fetch_rdata[31:16];
        pc_mem[wr_ptr] <= {word_pc, 1'b1};
      end else begin
        hw_mem[wr_ptr]    <= fetch_rdata[15:0];
        pc_mem[wr_ptr]    <= {word_pc, 1'b0};
        hw_mem[wr_ptr_p1] <= fetch_rdata[31:16];
        pc_mem[wr_ptr_p1] <= {word_pc, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - self-checking bench for fetch_buffer: vector table, corner sequences, random vs queue model
module tb_fetch_buffer;

  localparam int DEPTH = 8;
`ifdef COMPRESSED_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_rdata;
  logic        fetch_ready;
  logic        fetch_align;
  logic        fetch_clear;
  logic        pipe_stall;
  logic [31:0] buf_pc;
  logic [31:0] buf_instr;
  logic        buf_done;
  logic        buf_stall;

  always #5 clock = ~clock;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_pc    (fetch_pc),
    .fetch_rdata (fetch_rdata),
    .fetch_ready (fetch_ready),
    .fetch_align (fetch_align),
    .fetch_clear (fetch_clear),
    .pipe_stall  (pipe_stall),
    .buf_pc      (buf_pc),
    .buf_instr   (buf_instr),
    .buf_done    (buf_done),
    .buf_stall   (buf_stall)
  );

  typedef struct {
    logic [15:0] hw;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    logic        rdy;
    logic        al;
    logic        clr;
    logic        ps;
    logic [31:0] pc;
    logic [31:0] rd;
    logic        ed;
    logic [31:0] ep;
    logic [31:0] ei;
    logic        es;
  } vec_t;

  ent_t q[$];
  vec_t tbl[13];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  task automatic check(input string name, input logic ed, input logic [31:0] ep,
                       input logic [31:0] ei, input logic es);
    vectors++;
    if (buf_done !== ed || buf_pc !== ep || buf_instr !== ei || buf_stall !== es) begin
      miscompares++;
      $display("FAIL %s: got done=%0b pc=%h instr=%h stall=%0b, expected done=%0b pc=%h instr=%h stall=%0b",
               name, buf_done, buf_pc, buf_instr, buf_stall, ed, ep, ei, es);
    end
  endtask

  task automatic model_out(input logic clr, output logic ed, output logic [31:0] ep,
                           output logic [31:0] ei, output logic es, output int npop);
    bit short16;
    bit avail;
    ed = 1'b0; ep = '0; ei = '0; npop = 0;
    es = (q.size() > DEPTH - 2);
    if (q.size() > 0) begin
      short16 = CMP && (q[0].hw[1:0] != 2'b11);
      avail   = short16 || (q.size() >= 2);
      if (avail && !clr) begin
        ed   = 1'b1;
        ep   = q[0].pc;
        npop = short16 ? 1 : 2;
        if (short16) ei = {16'h0000, q[0].hw};
        else         ei = {q[1].hw, q[0].hw};
      end
    end
  endtask

  task automatic step(input logic rdy, input logic al, input logic clr, input logic ps,
                      input logic [31:0] pc, input logic [31:0] rd,
                      input bit chk, input string name, input logic ed_t,
                      input logic [31:0] ep_t, input logic [31:0] ei_t, input logic es_t);
    logic        ed;
    logic [31:0] ep;
    logic [31:0] ei;
    logic        es;
    int          npop;
    @(negedge clock);
    fetch_ready = rdy;
    fetch_align = al;
    fetch_clear = clr;
    pipe_stall  = ps;
    fetch_pc    = pc;
    fetch_rdata = rd;
    #1;
    model_out(clr, ed, ep, ei, es, npop);
    check($sformatf("model@%0d", cyc), ed, ep, ei, es);
    if (chk) check(name, ed_t, ep_t, ei_t, es_t);
    @(posedge clock);
    if (clr) begin
      q.delete();
    end else begin
      if (!ps) begin
        for (int k = 0; k < npop; k++) q.delete(0);
      end
      if (rdy && !es) begin
        if (CMP && al) begin
          q.push_back(ent_t'{rd[31:16], {pc[31:2], 2'b10}});
        end else begin
          q.push_back(ent_t'{rd[15:0],  {pc[31:2], 2'b00}});
          q.push_back(ent_t'{rd[31:16], {pc[31:2], 2'b10}});
        end
      end
    end
    cyc++;
  endtask

  task automatic go(input logic rdy, input logic al, input logic clr, input logic ps,
                    input logic [31:0] pc, input logic [31:0] rd);
    step(rdy, al, clr, ps, pc, rd, 1'b0, "", 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    reset       = 1'b0;
    fetch_ready = 1'b0;
    fetch_align = 1'b0;
    fetch_clear = 1'b0;
    pipe_stall  = 1'b0;
    fetch_pc    = '0;
    fetch_rdata = '0;

    //           rdy   al    clr   ps    pc            rdata         done  pc            instr         stall
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h00B5_0533, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0100, 32'h00B5_0533, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0104, 32'h1234_5677, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0108, 32'hAAAA_0013, 1'b1, 32'h0000_0104, 32'h1234_5677, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_010C, 32'h0000_0093, 1'b1, 32'h0000_0104, 32'h1234_5677, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0110, 32'hFFFF_FFFF, 1'b1, 32'h0000_0104, 32'h1234_5677, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0114, 32'h1111_1113, 1'b1, 32'h0000_0104, 32'h1234_5677, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0104, 32'h1234_5677, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0108, 32'hAAAA_0013, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h2222_0003, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};

    @(posedge clock);
    #1;
    check("reset_state", 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rdy, tbl[i].al, tbl[i].clr, tbl[i].ps, tbl[i].pc, tbl[i].rd,
           1'b1, $sformatf("table[%0d]", i), tbl[i].ed, tbl[i].ep, tbl[i].ei, tbl[i].es);
    end

    // Clear collides with a ready word at count 6: no presentation, no push.
    go(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0600, 32'h0000_0003);
    go(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0604, 32'h0000_0007);
    go(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0608, 32'h0000_000B);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_060C, 32'h0000_000F, 1'b1, "clear_cycle",
         1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "after_clear", 1'b0, 32'h0, 32'h0, 1'b0);

`ifdef COMPRESSED_EN
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'h4501_4185, 1'b1, "rvc_push",
         1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "rvc_first",
         1'b1, 32'h0000_0200, 32'h0000_4185, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "rvc_second",
         1'b1, 32'h0000_0202, 32'h0000_4501, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "rvc_empty", 1'b0, 32'h0, 32'h0, 1'b0);

    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0302, 32'h0513_0000, 1'b1, "align_push",
         1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0304, 32'h0000_0000, 1'b1, "align_half_only",
         1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "align_joined",
         1'b1, 32'h0000_0302, 32'h0000_0513, 1'b0);
    go(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    go(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
`endif

    // Asynchronous reset with a partly full buffer.
    go(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0400, 32'h0000_0003);
    go(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0404, 32'h0000_0007);
    go(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0408, 32'h0000_000B);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, "pre_reset",
         1'b1, 32'h0000_0400, 32'h0000_0003, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("async_reset", 1'b0, 32'h0, 32'h0, 1'b0);
    q.delete();
    @(posedge clock);
    #1;
    check("held_reset", 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "post_reset_empty", 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0500, 32'h00B5_0533, 1'b1, "post_reset_push",
         1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "post_reset_present",
         1'b1, 32'h0000_0500, 32'h00B5_0533, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      go($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0,
         $urandom_range(0, 2) == 0, $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
